// File: rtl/pokey_irq_core.sv
// POKEY interrupt controller core.
// Holds the IRQEN enable mask and the IRQST status register. It drives the CPU
// IRQ line and pulses overrun flags for the keyboard and serial-input sources.
// State advances on phase-1 (enp) edges. Dr/IRQ are re-registered on phase-2
// (enn) edges, so the CPU sees a change half a slow cycle after the sample.
module pokey_irq_core (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enn,
  input  logic       enp,
  input  logic       IRQEN,
  input  logic [7:0] Dw,
  input  logic       setBreak,
  input  logic       setKey,
  input  logic       setSdiCompl,
  input  logic       setSdoCompl,
  input  logic       sdoFinish,
  input  logic       Timer4,
  input  logic       Timer2,
  input  logic       Timer1,
  output logic       IRQ,
  output logic [7:0] Dr,
  output logic       keyOvrun,
  output logic       sdiOvrun
);

  // Bit 3 (serial output finished) is a live level, not a latched flag.
  localparam logic [7:0] LATCH_MASK = 8'hF7;

  logic [7:0] r_en;
  logic [7:0] r_stat;
  logic [7:0] r_dr;
  logic       r_irq;
  logic       r_key_ovrun;
  logic       r_sdi_ovrun;

  logic [7:0] w_events;
  logic [7:0] w_en_next;
  logic [7:0] w_stat_wr;
  logic [7:0] w_stat_next;
  logic       w_key_ovr;
  logic       w_sdi_ovr;
  logic       w_st3;
  logic [7:0] w_view;

  assign w_events = {setBreak, setKey, setSdiCompl, setSdoCompl,
                     1'b0, Timer4, Timer2, Timer1};

  // Next enable mask and status: apply the IRQEN write first, then the events.
  always_comb begin
    w_en_next = r_en;
    w_stat_wr = r_stat;
    if (IRQEN) begin
      w_en_next = Dw;
      w_stat_wr = r_stat | (~Dw & LATCH_MASK);
    end else begin
      w_en_next = r_en;
      w_stat_wr = r_stat;
    end
    // An event only marks a pending bit when that source is enabled.
    // Bit 3 is forced to 1 because it is not stored.
    w_stat_next = (w_stat_wr & ~(w_events & w_en_next)) | ~LATCH_MASK;
    // Overrun: a fresh event arrives while the bit is still pending after the write.
    w_key_ovr   = setKey      & w_en_next[6] & ~w_stat_wr[6];
    w_sdi_ovr   = setSdiCompl & w_en_next[5] & ~w_stat_wr[5];
  end

  assign w_st3  = sdoFinish | ~r_en[3];
  assign w_view = {r_stat[7:4], w_st3, r_stat[2:0]};

  // Enable mask, status and overrun pulses advance on phase-1 edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en        <= 8'h00;
      r_stat      <= 8'hFF;
      r_key_ovrun <= 1'b0;
      r_sdi_ovrun <= 1'b0;
    end else if (enp) begin
      r_en        <= w_en_next;
      r_stat      <= w_stat_next;
      r_key_ovrun <= w_key_ovr;
      r_sdi_ovrun <= w_sdi_ovr;
    end else begin
      r_en        <= r_en;
      r_stat      <= r_stat;
      r_key_ovrun <= r_key_ovrun;
      r_sdi_ovrun <= r_sdi_ovrun;
    end
  end

  // IRQST read data and the IRQ line are refreshed on phase-2 edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dr  <= 8'hFF;
      r_irq <= 1'b0;
    end else if (enn) begin
      r_dr  <= w_view;
      r_irq <= ~(&w_view);
    end else begin
      r_dr  <= r_dr;
      r_irq <= r_irq;
    end
  end

  assign Dr       = r_dr;
  assign IRQ      = r_irq;
  assign keyOvrun = r_key_ovrun;
  assign sdiOvrun = r_sdi_ovrun;

endmodule

// File: tb/tb_pokey_irq_core.sv
// Directed and random checks of pokey_irq_core against a flag-per-source model.
module tb_pokey_irq_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enn = 1'b0;
  logic       enp = 1'b0;
  logic       IRQEN = 1'b0;
  logic [7:0] Dw = 8'h00;
  logic       setBreak = 1'b0;
  logic       setKey = 1'b0;
  logic       setSdiCompl = 1'b0;
  logic       setSdoCompl = 1'b0;
  logic       sdoFinish = 1'b1;
  logic       Timer4 = 1'b0;
  logic       Timer2 = 1'b0;
  logic       Timer1 = 1'b0;
  logic       IRQ;
  logic [7:0] Dr;
  logic       keyOvrun;
  logic       sdiOvrun;

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  // Reference model: enable bits, pending flags, current overruns, live bit-3 level.
  bit m_en   [8];
  bit m_pend [8];
  bit m_kov;
  bit m_sov;
  bit m_sdo_low;

  pokey_irq_core dut (
    .clk(clk), .reset_n(reset_n), .enn(enn), .enp(enp), .IRQEN(IRQEN), .Dw(Dw),
    .setBreak(setBreak), .setKey(setKey), .setSdiCompl(setSdiCompl),
    .setSdoCompl(setSdoCompl), .sdoFinish(sdoFinish), .Timer4(Timer4),
    .Timer2(Timer2), .Timer1(Timer1), .IRQ(IRQ), .Dr(Dr),
    .keyOvrun(keyOvrun), .sdiOvrun(sdiOvrun)
  );

  always #10 clk = ~clk;

  // Slow-clock phase enables: 8 fast clocks per slow cycle, enp and enn half a cycle apart.
  initial begin
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 8;
      enp = (phase == 0);
      enn = (phase == 4);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_kov = 1'b0;
    m_sov = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] e_dr;
    logic       e_irq;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) e_dr[i] = !(m_sdo_low && m_en[3]);
      else        e_dr[i] = !m_pend[i];
    end
    e_irq = (e_dr != 8'hFF);
    checks++;
    assert (Dr === e_dr) else begin
      errors++; $error("FAIL %s Dr observed=%h expected=%h", tag, Dr, e_dr);
    end
    checks++;
    assert (IRQ === e_irq) else begin
      errors++; $error("FAIL %s IRQ observed=%b expected=%b", tag, IRQ, e_irq);
    end
    checks++;
    assert (keyOvrun === m_kov) else begin
      errors++; $error("FAIL %s keyOvrun observed=%b expected=%b", tag, keyOvrun, m_kov);
    end
    checks++;
    assert (sdiOvrun === m_sov) else begin
      errors++; $error("FAIL %s sdiOvrun observed=%b expected=%b", tag, sdiOvrun, m_sov);
    end
  endtask

  // One slow cycle: ev[3]=1 means sdoFinish low; check after the following enn.
  task automatic cycle(input logic [7:0] ev, input logic wr, input logic [7:0] dw,
                       input string tag);
    int guard = 0;
    do begin @(negedge clk); #1; guard++; end while (enp !== 1'b1 && guard < 40);
    IRQEN = wr; Dw = dw;
    setBreak = ev[7]; setKey = ev[6]; setSdiCompl = ev[5]; setSdoCompl = ev[4];
    sdoFinish = ~ev[3]; Timer4 = ev[2]; Timer2 = ev[1]; Timer1 = ev[0];
    @(posedge clk);
    if (wr) begin
      for (int i = 0; i < 8; i++) begin
        m_en[i] = dw[i];
        if (i != 3 && !dw[i]) m_pend[i] = 1'b0;
      end
    end
    m_kov = ev[6] && m_pend[6];
    m_sov = ev[5] && m_pend[5];
    for (int i = 0; i < 8; i++)
      if (i != 3 && ev[i] && m_en[i]) m_pend[i] = 1'b1;
    m_sdo_low = ev[3];
    guard = 0;
    do begin @(negedge clk); #1; guard++; end while (enn !== 1'b1 && guard < 40);
    checks++;
    assert (guard < 40) else begin
      errors++; $error("FAIL %s enable_timeout observed=%0d expected<40", tag, guard);
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (Dr === 8'hFF) else begin
      errors++; $error("FAIL %s Dr observed=%h expected=ff", tag, Dr);
    end
    checks++;
    assert (IRQ === 1'b0 && keyOvrun === 1'b0 && sdiOvrun === 1'b0) else begin
      errors++; $error("FAIL %s irq/ovr observed=%b%b%b expected=000", tag, IRQ, keyOvrun, sdiOvrun);
    end
  endtask

  initial begin
    logic [7:0] tsrc [3];
    logic [7:0] ev;
    logic [7:0] dw;
    logic       wr;
    tsrc[0] = 8'h01; tsrc[1] = 8'h02; tsrc[2] = 8'h04;
    model_reset();
    m_sdo_low = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) reset_n = 1'b1;

    // All events with everything disabled.
    cycle(8'h00, 1'b1, 8'h00, "wr_zero");
    cycle(8'hFF, 1'b0, 8'h00, "all_disabled");
    cycle(8'h00, 1'b0, 8'h00, "idle");

    // Timers 1, 2, 4.
    for (int k = 0; k < 3; k++) begin
      cycle(8'h00,   1'b1, tsrc[k], "tmr_en");
      cycle(tsrc[k], 1'b0, 8'h00,   "tmr_pulse");
      cycle(8'h00,   1'b0, 8'h00,   "tmr_hold");
      cycle(8'h00,   1'b1, 8'h00,   "tmr_clr");
    end

    // Bit 3 follows the sdoFinish level.
    cycle(8'h00, 1'b1, 8'h08, "sdo_en");
    cycle(8'h08, 1'b0, 8'h00, "sdo_low");
    cycle(8'h00, 1'b0, 8'h00, "sdo_high");
    cycle(8'h08, 1'b0, 8'h00, "sdo_low2");
    cycle(8'h00, 1'b1, 8'h00, "sdo_clr");

    // Serial input and keyboard overruns.
    cycle(8'h00, 1'b1, 8'h20, "sdi_en");
    cycle(8'h20, 1'b0, 8'h00, "sdi_first");
    cycle(8'h00, 1'b0, 8'h00, "sdi_gap");
    cycle(8'h20, 1'b0, 8'h00, "sdi_ovr");
    cycle(8'h00, 1'b0, 8'h00, "sdi_ovr_end");
    cycle(8'h00, 1'b1, 8'h00, "sdi_clr");
    cycle(8'h00, 1'b1, 8'h40, "key_en");
    cycle(8'h40, 1'b0, 8'h00, "key_first");
    cycle(8'h40, 1'b0, 8'h00, "key_ovr");
    cycle(8'h00, 1'b0, 8'h00, "key_ovr_end");
    cycle(8'h40, 1'b1, 8'h00, "key_write_wins");
    cycle(8'h00, 1'b0, 8'h00, "key_cleared");

    // Serial output needed and break: no overruns.
    cycle(8'h00, 1'b1, 8'h10, "sdoc_en");
    cycle(8'h10, 1'b0, 8'h00, "sdoc_pulse");
    cycle(8'h10, 1'b0, 8'h00, "sdoc_repeat");
    cycle(8'h00, 1'b1, 8'h80, "brk_en");
    cycle(8'h80, 1'b0, 8'h00, "brk_pulse");
    cycle(8'h80, 1'b0, 8'h00, "brk_repeat");

    // Asynchronous reset while pending.
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_reset("reset_pending");
    @(negedge clk) reset_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      ev = 8'h00;
      for (int b = 0; b < 8; b++) ev[b] = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 4) == 0);
      dw = 8'($urandom_range(0, 255));
      cycle(ev, wr, dw, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
